// File: rtl/nibble_serial_addsub.sv
// Serial add/subtract built around a single 4-bit adder slice, one nibble per clock, LSB first.
// Subtraction runs as A + ~B + carry, so CO = 1 on SUB means no borrow.
module nibble_serial_addsub #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             ARST,
  input  logic             START,
  input  logic             SUB,
  input  logic             CI,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Y,
  output logic             CO,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int unsigned TOP = WIDTH - 4;

  if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
    $error("nibble_serial_addsub: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  opa_q, opa_d;
  logic [WIDTH-1:0]  opb_q, opb_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic              co_q, co_d;
  logic              done_q, done_d;
  logic [4:0]        sum;

  // State and datapath registers
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      done_q  <= done_d;
    end
  end

  // The shared 4-bit slice: low nibbles plus the carry held between steps
  assign sum = 5'({1'b0, opa_q[3:0]}) + 5'({1'b0, opb_q[3:0]}) + 5'(carry_q);

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    co_d    = co_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          opa_d   = A;
          opb_d   = SUB ? ~B : B;
          carry_d = CI ^ SUB;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        y_d     = (y_q >> 4) | (WIDTH'(sum[3:0]) << TOP);
        opa_d   = opa_q >> 4;
        opb_d   = opb_q >> 4;
        carry_d = sum[4];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NIB - 1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          co_d    = sum[4];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign Y    = y_q;
  assign CO   = co_q;
  assign BUSY = (state_q == S_RUN);
  assign DONE = done_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Bench for nibble_serial_addsub: 16-bit and 4-bit instances against an arithmetic reference.
`timescale 1ns/1ps
module tb_nibble_serial_addsub;

  logic        clk;
  logic        arst;

  logic        start, sub, ci;
  logic [15:0] a, b, y;
  logic        co, busy, done;

  logic        start4, sub4, ci4;
  logic [3:0]  a4, b4, y4;
  logic        co4, busy4, done4;

  int nvec = 0;
  int nerr = 0;

  nibble_serial_addsub #(.WIDTH(16)) dut16 (
    .CLK(clk), .ARST(arst), .START(start), .SUB(sub), .CI(ci),
    .A(a), .B(b), .Y(y), .CO(co), .BUSY(busy), .DONE(done)
  );

  nibble_serial_addsub #(.WIDTH(4)) dut4 (
    .CLK(clk), .ARST(arst), .START(start4), .SUB(sub4), .CI(ci4),
    .A(a4), .B(b4), .Y(y4), .CO(co4), .BUSY(busy4), .DONE(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain wide arithmetic, bit WIDTH is the carry-out
  function automatic logic [16:0] model16(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic ms, input logic mc);
    logic [16:0] bb;
    bb = ms ? {1'b0, ~mb} : {1'b0, mb};
    return {1'b0, ma} + bb + 17'(mc ^ ms);
  endfunction

  function automatic logic [4:0] model4(input logic [3:0] ma, input logic [3:0] mb,
                                        input logic ms, input logic mc);
    logic [4:0] bb;
    bb = ms ? {1'b0, ~mb} : {1'b0, mb};
    return {1'b0, ma} + bb + 5'(mc ^ ms);
  endfunction

  // Launch one 16-bit operation and observe BUSY/DONE until two cycles past the first DONE
  task automatic run16(input logic [15:0] ta, input logic [15:0] tb_, input logic ts, input logic tc,
                       output logic [15:0] ry, output logic rco,
                       output int nbusy, output int lat, output int ndone);
    ry = '0; rco = 1'b0; nbusy = 0; lat = 0; ndone = 0;
    @(negedge clk);
    a = ta; b = tb_; sub = ts; ci = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (lat == 0) begin lat = i; ry = y; rco = co; end
      end
      if (lat != 0 && i >= lat + 2) break;
      @(negedge clk);
    end
  endtask

  task automatic run4(input logic [3:0] ta, input logic [3:0] tb_, input logic ts, input logic tc,
                      output logic [3:0] ry, output logic rco,
                      output int nbusy, output int lat, output int ndone);
    ry = '0; rco = 1'b0; nbusy = 0; lat = 0; ndone = 0;
    @(negedge clk);
    a4 = ta; b4 = tb_; sub4 = ts; ci4 = tc; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      if (busy4) nbusy++;
      if (done4) begin
        ndone++;
        if (lat == 0) begin lat = i; ry = y4; rco = co4; end
      end
      if (lat != 0 && i >= lat + 2) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    arst = 1'b1;
    repeat (2) @(negedge clk);
    nvec++; if (y !== 16'h0000) begin nerr++; $display("FAIL reset_y: got %h expected 0000", y); end
    nvec++; if ({co, busy, done} !== 3'b000) begin nerr++; $display("FAIL reset_flags: got co/busy/done=%b expected 000", {co, busy, done}); end
    nvec++; if ({y4, co4, busy4, done4} !== 7'd0) begin nerr++; $display("FAIL reset_w4: got %b expected 0", {y4, co4, busy4, done4}); end
    arst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [15:0] va [6] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h0005, 16'h0007, 16'h0007};
    logic [15:0] vb [6] = '{16'h4321, 16'h0001, 16'h0001, 16'h0007, 16'h0005, 16'h0005};
    logic        vs [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        vc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] ey [6] = '{16'h5555, 16'h0000, 16'h0001, 16'hFFFE, 16'h0002, 16'h0001};
    logic        ec [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [15:0] ry;
    logic        rco;
    int          nb, lat, nd;
    for (int i = 0; i < 6; i++) begin
      run16(va[i], vb[i], vs[i], vc[i], ry, rco, nb, lat, nd);
      nvec++; if (ry !== ey[i]) begin nerr++; $display("FAIL directed_y[%0d]: got %h expected %h", i, ry, ey[i]); end
      nvec++; if (rco !== ec[i]) begin nerr++; $display("FAIL directed_co[%0d]: got %b expected %b", i, rco, ec[i]); end
      nvec++; if (nb !== 4) begin nerr++; $display("FAIL directed_busy_cycles[%0d]: got %0d expected 4", i, nb); end
      nvec++; if (lat !== 5) begin nerr++; $display("FAIL directed_latency[%0d]: got %0d expected 5", i, lat); end
      nvec++; if (nd !== 1) begin nerr++; $display("FAIL directed_done_pulses[%0d]: got %0d expected 1", i, nd); end
    end
  endtask

  task automatic test_random();
    logic [15:0] ta, tb_, ry;
    logic        ts, tc, rco;
    logic [16:0] exp_r;
    int          nb, lat, nd;
    for (int i = 0; i < 30; i++) begin
      ta = 16'($urandom); tb_ = 16'($urandom);
      ts = 1'($urandom); tc = 1'($urandom);
      exp_r = model16(ta, tb_, ts, tc);
      run16(ta, tb_, ts, tc, ry, rco, nb, lat, nd);
      nvec++; if ({rco, ry} !== exp_r) begin nerr++; $display("FAIL random[%0d] %h %s %h ci=%b: got co=%b y=%h expected co=%b y=%h", i, ta, ts ? "-" : "+", tb_, tc, rco, ry, exp_r[16], exp_r[15:0]); end
      nvec++; if (lat !== 5 || nd !== 1) begin nerr++; $display("FAIL random_timing[%0d]: got lat=%0d dones=%0d expected lat=5 dones=1", i, lat, nd); end
    end
  endtask

  // START while busy is ignored; START in the DONE cycle is accepted
  task automatic test_back_to_back();
    logic [15:0] y1, y2, a2, b2;
    logic        co1, co2, s2, c2;
    logic [16:0] exp2;
    int          lat1, lat2, nd;
    lat1 = 0; lat2 = 0; nd = 0; y1 = '0; y2 = '0; co1 = 1'b0; co2 = 1'b0;
    a2 = 16'($urandom); b2 = 16'($urandom); s2 = 1'($urandom); c2 = 1'($urandom);
    exp2 = model16(a2, b2, s2, c2);
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; sub = 1'b0; ci = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      start = 1'b0;
      if (done) begin
        nd++;
        if (lat1 == 0) begin
          lat1 = i; y1 = y; co1 = co;
          a = a2; b = b2; sub = s2; ci = c2; start = 1'b1;
        end else if (lat2 == 0) begin
          lat2 = i; y2 = y; co2 = co;
        end
      end else if (i == 2 || i == 3) begin
        a = 16'($urandom); b = 16'($urandom); sub = ~sub; ci = 1'($urandom); start = 1'b1;
      end
      if (lat2 != 0 && i >= lat2 + 2) break;
      @(negedge clk);
    end
    start = 1'b0;
    nvec++; if (y1 !== 16'h5555 || co1 !== 1'b0) begin nerr++; $display("FAIL ignore_start_result: got co=%b y=%h expected co=0 y=5555", co1, y1); end
    nvec++; if (lat1 !== 5) begin nerr++; $display("FAIL ignore_start_latency: got %0d expected 5", lat1); end
    nvec++; if (lat2 - lat1 !== 5) begin nerr++; $display("FAIL b2b_period: got %0d expected 5", lat2 - lat1); end
    nvec++; if ({co2, y2} !== exp2) begin nerr++; $display("FAIL b2b_result: got co=%b y=%h expected co=%b y=%h", co2, y2, exp2[16], exp2[15:0]); end
    nvec++; if (nd !== 2) begin nerr++; $display("FAIL b2b_done_count: got %0d expected 2", nd); end
  endtask

  task automatic test_async_reset();
    logic [15:0] ry;
    logic        rco;
    int          nb, lat, nd;
    run16(16'hFFFF, 16'h0001, 1'b0, 1'b0, ry, rco, nb, lat, nd);
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0000; sub = 1'b0; ci = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    nvec++; if (busy !== 1'b1 || y === 16'h0000 || co !== 1'b1) begin nerr++; $display("FAIL pre_reset_state: got busy=%b y=%h co=%b expected busy=1 y!=0 co=1", busy, y, co); end
    #1 arst = 1'b1;
    #1;
    nvec++; if (y !== 16'h0000) begin nerr++; $display("FAIL async_reset_y: got %h expected 0000", y); end
    nvec++; if ({co, busy, done} !== 3'b000) begin nerr++; $display("FAIL async_reset_flags: got co/busy/done=%b expected 000", {co, busy, done}); end
    @(negedge clk);
    arst = 1'b0;
    run16(16'h00FF, 16'h0001, 1'b0, 1'b0, ry, rco, nb, lat, nd);
    nvec++; if (ry !== 16'h0100 || rco !== 1'b0) begin nerr++; $display("FAIL post_reset_op: got co=%b y=%h expected co=0 y=0100", rco, ry); end
    nvec++; if (lat !== 5 || nb !== 4) begin nerr++; $display("FAIL post_reset_timing: got lat=%0d busy=%0d expected lat=5 busy=4", lat, nb); end
  endtask

  task automatic test_width4();
    logic [3:0] ta, tb_, ry;
    logic       ts, tc, rco;
    logic [4:0] exp_r;
    int         nb, lat, nd;
    run4(4'h9, 4'h8, 1'b0, 1'b0, ry, rco, nb, lat, nd);
    nvec++; if (ry !== 4'h1 || rco !== 1'b1) begin nerr++; $display("FAIL w4_directed: got co=%b y=%h expected co=1 y=1", rco, ry); end
    nvec++; if (nb !== 1 || lat !== 2 || nd !== 1) begin nerr++; $display("FAIL w4_timing: got busy=%0d lat=%0d dones=%0d expected 1/2/1", nb, lat, nd); end
    for (int i = 0; i < 16; i++) begin
      ta = 4'($urandom); tb_ = 4'($urandom); ts = 1'($urandom); tc = 1'($urandom);
      exp_r = model4(ta, tb_, ts, tc);
      run4(ta, tb_, ts, tc, ry, rco, nb, lat, nd);
      nvec++; if ({rco, ry} !== exp_r || lat !== 2) begin nerr++; $display("FAIL w4_random[%0d] %h %s %h ci=%b: got co=%b y=%h lat=%0d expected co=%b y=%h lat=2", i, ta, ts ? "-" : "+", tb_, tc, rco, ry, lat, exp_r[4], exp_r[3:0]); end
    end
  endtask

  initial begin
    arst = 1'b1;
    start = 1'b0; sub = 1'b0; ci = 1'b0; a = '0; b = '0;
    start4 = 1'b0; sub4 = 1'b0; ci4 = 1'b0; a4 = '0; b4 = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_async_reset();
    test_width4();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
